// File: rtl/ps2_key_decoder.sv
// PS/2 Set 2 scan-code decoder: assembles prefix sequences into a 16-bit
// keycode with a one-cycle event strobe, and tracks held arrow / WASD keys
// as level-type movement flags.
module ps2_key_decoder #(
   parameter bit ENABLE_WASD    = 1'b1,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic [15:0] keycode,
   output logic        key_event,
   output logic        move_up,
   output logic        move_down,
   output logic        move_right,
   output logic        move_left
);

   localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_EXT     = 2'd1;
   localparam logic [1:0] S_BRK     = 2'd2;
   localparam logic [1:0] S_EXT_BRK = 2'd3;

   // Direction bit order in all 4-bit vectors: {up, down, right, left}
   logic [1:0]    r_state;
   logic [CW-1:0] r_cnt;
   logic [15:0]   r_keycode;
   logic          r_event;
   logic [3:0]    r_arrow;
   logic [3:0]    r_wasd;
   logic [3:0]    r_move;

   logic [1:0]    w_state_nx;
   logic [CW-1:0] w_cnt_nx;
   logic [15:0]   w_keycode_nx;
   logic          w_event_nx;
   logic [3:0]    w_arrow_nx;
   logic [3:0]    w_wasd_nx;
   logic [3:0]    w_move_nx;
   logic [3:0]    w_arrow_hit;
   logic [3:0]    w_wasd_hit;
   logic          w_ignore;
   logic          w_expired;

   // Decode which tracked key, if any, the incoming byte names
   always_comb begin
      w_arrow_hit = {rx_data == 8'h75, rx_data == 8'h72,
                     rx_data == 8'h74, rx_data == 8'h6B};
      w_wasd_hit  = {rx_data == 8'h1D, rx_data == 8'h1B,
                     rx_data == 8'h23, rx_data == 8'h1C};
      w_ignore    = (rx_data == 8'hE1) || (rx_data == 8'hAA) ||
                    (rx_data == 8'hFA) || (rx_data == 8'hFE) ||
                    (rx_data == 8'hEE);
      w_expired   = (r_cnt == CW'(TIMEOUT_CYCLES - 1));
   end

   // Sequence FSM, timeout counter and pressed-key tracking (next state)
   always_comb begin
      w_state_nx   = r_state;
      w_cnt_nx     = r_cnt;
      w_keycode_nx = r_keycode;
      w_event_nx   = 1'b0;
      w_arrow_nx   = r_arrow;
      w_wasd_nx    = r_wasd;
      if (rx_valid) begin
         // A byte always wins over an expiring timeout
         w_cnt_nx = '0;
         case (r_state)
            S_IDLE: begin
               if (rx_data == 8'hE0) begin
                  w_state_nx = S_EXT;
               end else if (rx_data == 8'hF0) begin
                  w_state_nx = S_BRK;
               end else if (!w_ignore) begin
                  w_keycode_nx = {8'h00, rx_data};
                  w_event_nx   = 1'b1;
                  w_wasd_nx    = r_wasd | w_wasd_hit;
               end
            end
            S_EXT: begin
               if (rx_data == 8'hF0) begin
                  w_state_nx = S_EXT_BRK;
               end else if (rx_data != 8'hE0) begin
                  w_keycode_nx = {8'hE0, rx_data};
                  w_event_nx   = 1'b1;
                  w_arrow_nx   = r_arrow | w_arrow_hit;
                  w_state_nx   = S_IDLE;
               end
            end
            S_BRK: begin
               w_keycode_nx = {8'hF0, rx_data};
               w_event_nx   = 1'b1;
               w_wasd_nx    = r_wasd & ~w_wasd_hit;
               w_state_nx   = S_IDLE;
            end
            default: begin
               w_keycode_nx = {8'hF0, rx_data};
               w_event_nx   = 1'b1;
               w_arrow_nx   = r_arrow & ~w_arrow_hit;
               w_state_nx   = S_IDLE;
            end
         endcase
      end else if (r_state != S_IDLE) begin
         if (w_expired) begin
            w_state_nx = S_IDLE;
            w_cnt_nx   = '0;
         end else begin
            w_cnt_nx = r_cnt + CW'(1);
         end
      end else begin
         w_cnt_nx = '0;
      end
      w_move_nx = w_arrow_nx | (ENABLE_WASD ? w_wasd_nx : 4'b0000);
   end

   // Register state, outputs and pressed bits
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_keycode <= '0;
         r_event   <= 1'b0;
         r_arrow   <= '0;
         r_wasd    <= '0;
         r_move    <= '0;
      end else begin
         r_state   <= w_state_nx;
         r_cnt     <= w_cnt_nx;
         r_keycode <= w_keycode_nx;
         r_event   <= w_event_nx;
         r_arrow   <= w_arrow_nx;
         r_wasd    <= w_wasd_nx;
         r_move    <= w_move_nx;
      end
   end

   assign keycode    = r_keycode;
   assign key_event  = r_event;
   assign move_up    = r_move[3];
   assign move_down  = r_move[2];
   assign move_right = r_move[1];
   assign move_left  = r_move[0];

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: a WASD-enabled instance checked
// fully, plus an arrows-only instance whose move_up is checked alongside.
module tb_ps2_key_decoder;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic [15:0] keycode, keycode2;
   logic        key_event, key_event2;
   logic        move_up, move_down, move_right, move_left;
   logic        up2, down2, right2, left2;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   ps2_key_decoder #(.ENABLE_WASD(1'b1), .TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
      .keycode(keycode), .key_event(key_event),
      .move_up(move_up), .move_down(move_down),
      .move_right(move_right), .move_left(move_left)
   );

   ps2_key_decoder #(.ENABLE_WASD(1'b0), .TIMEOUT_CYCLES(8)) dut2 (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
      .keycode(keycode2), .key_event(key_event2),
      .move_up(up2), .move_down(down2),
      .move_right(right2), .move_left(left2)
   );

   typedef struct {
      logic [7:0]  b;
      logic        evt;
      logic [15:0] kc;
      logic [3:0]  mv;   // {up, down, right, left}
      logic        up2;  // arrows-only instance move_up
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(logic [7:0] b, logic evt, logic [15:0] kc,
                               logic [3:0] mv, logic u2);
      vec_t v;
      v.b = b; v.evt = evt; v.kc = kc; v.mv = mv; v.up2 = u2;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] got,
                      input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Called at a negedge; byte is sampled at the next posedge, returns at
   // the following negedge where the resulting outputs are visible.
   task automatic send(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic chk_out(input string name, input logic evt,
                          input logic [15:0] kc, input logic [3:0] mv);
      chk({name, " event"}, 32'(key_event), 32'(evt));
      chk({name, " keycode"}, 32'(keycode), 32'(kc));
      chk({name, " moves"}, 32'({move_up, move_down, move_right, move_left}),
          32'(mv));
   endtask

   initial begin
      rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk_out("reset", 1'b0, 16'h0000, 4'b0000);
      chk("reset up2", 32'(up2), 32'd0);

      tbl.push_back(mk(8'h1C, 1, 16'h001C, 4'b0001, 0));
      tbl.push_back(mk(8'hF0, 0, 16'h001C, 4'b0001, 0));
      tbl.push_back(mk(8'h1C, 1, 16'hF01C, 4'b0000, 0));
      tbl.push_back(mk(8'hE0, 0, 16'hF01C, 4'b0000, 0));
      tbl.push_back(mk(8'h75, 1, 16'hE075, 4'b1000, 1));
      tbl.push_back(mk(8'hE0, 0, 16'hE075, 4'b1000, 1));
      tbl.push_back(mk(8'hF0, 0, 16'hE075, 4'b1000, 1));
      tbl.push_back(mk(8'h75, 1, 16'hF075, 4'b0000, 0));
      tbl.push_back(mk(8'h75, 1, 16'h0075, 4'b0000, 0));
      tbl.push_back(mk(8'hE0, 0, 16'h0075, 4'b0000, 0));
      tbl.push_back(mk(8'h75, 1, 16'hE075, 4'b1000, 1));
      tbl.push_back(mk(8'h1D, 1, 16'h001D, 4'b1000, 1));
      tbl.push_back(mk(8'hE0, 0, 16'h001D, 4'b1000, 1));
      tbl.push_back(mk(8'hF0, 0, 16'h001D, 4'b1000, 1));
      tbl.push_back(mk(8'h75, 1, 16'hF075, 4'b1000, 0));
      tbl.push_back(mk(8'hF0, 0, 16'hF075, 4'b1000, 0));
      tbl.push_back(mk(8'h1D, 1, 16'hF01D, 4'b0000, 0));
      tbl.push_back(mk(8'h1D, 1, 16'h001D, 4'b1000, 0));
      tbl.push_back(mk(8'hF0, 0, 16'h001D, 4'b1000, 0));
      tbl.push_back(mk(8'h1D, 1, 16'hF01D, 4'b0000, 0));
      tbl.push_back(mk(8'hE1, 0, 16'hF01D, 4'b0000, 0));
      tbl.push_back(mk(8'hAA, 0, 16'hF01D, 4'b0000, 0));
      tbl.push_back(mk(8'hFA, 0, 16'hF01D, 4'b0000, 0));
      tbl.push_back(mk(8'hFE, 0, 16'hF01D, 4'b0000, 0));
      tbl.push_back(mk(8'hEE, 0, 16'hF01D, 4'b0000, 0));
      tbl.push_back(mk(8'hE0, 0, 16'hF01D, 4'b0000, 0));
      tbl.push_back(mk(8'hE0, 0, 16'hF01D, 4'b0000, 0));
      tbl.push_back(mk(8'h72, 1, 16'hE072, 4'b0100, 0));
      tbl.push_back(mk(8'hE0, 0, 16'hE072, 4'b0100, 0));
      tbl.push_back(mk(8'hF0, 0, 16'hE072, 4'b0100, 0));
      tbl.push_back(mk(8'h72, 1, 16'hF072, 4'b0000, 0));
      tbl.push_back(mk(8'h1B, 1, 16'h001B, 4'b0100, 0));
      tbl.push_back(mk(8'hF0, 0, 16'h001B, 4'b0100, 0));
      tbl.push_back(mk(8'h1B, 1, 16'hF01B, 4'b0000, 0));

      // Back-to-back bytes, checked after each one
      for (int i = 0; i < tbl.size(); i++) begin
         send(tbl[i].b);
         chk_out($sformatf("vec%0d", i), tbl[i].evt, tbl[i].kc, tbl[i].mv);
         chk($sformatf("vec%0d up2", i), 32'(up2), 32'(tbl[i].up2));
      end

      // Event is a single-cycle pulse; keycode holds
      @(negedge clk);
      chk_out("pulse end", 1'b0, 16'hF01B, 4'b0000);

      // E0 abandoned after a full timeout: 74 becomes a normal make
      send(8'hE0);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk($sformatf("timeout wait %0d event", i), 32'(key_event), 32'd0);
      end
      send(8'h74);
      chk_out("after timeout", 1'b1, 16'h0074, 4'b0000);

      // E0 then byte on the expiry cycle: still extended
      send(8'hE0);
      repeat (7) @(negedge clk);
      send(8'h74);
      chk_out("ext on expiry", 1'b1, 16'hE074, 4'b0010);
      send(8'hE0); send(8'hF0); send(8'h74);
      chk_out("right arrow release", 1'b1, 16'hF074, 4'b0000);

      // D held, F0 then 23 on the expiry cycle: still a break
      send(8'h23);
      chk_out("D make", 1'b1, 16'h0023, 4'b0010);
      send(8'hF0);
      repeat (7) @(negedge clk);
      send(8'h23);
      chk_out("break on expiry", 1'b1, 16'hF023, 4'b0000);

      // Reset mid-sequence discards the E0 prefix and pressed bits
      send(8'hE0); send(8'h72);
      chk_out("down make", 1'b1, 16'hE072, 4'b0100);
      send(8'hE0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk_out("mid reset", 1'b0, 16'h0000, 4'b0000);
      send(8'h6B);
      chk_out("6B after reset", 1'b1, 16'h006B, 4'b0000);

      // Ignored bytes in IDLE give no event
      send(8'hAA);
      chk("AA event", 32'(key_event), 32'd0);
      send(8'hFA);
      chk("FA event", 32'(key_event), 32'd0);
      chk("ignored keycode", 32'(keycode), 32'h006B);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
